// File: rtl/ram_arb_pkg.sv
//==============================================================================
// Module : ram_arb_pkg
// Desc   : Shared types and constants for the two-port SRAM arbiter.
// Rev    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package ram_arb_pkg;

   localparam int RAM_DW = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef logic port_id_t;

endpackage

`default_nettype wire

// File: rtl/ram_arb_pick.sv
//==============================================================================
// Module : arb2_pick
// Desc   : Combinational 2-way request picker. Round-robin by default;
//          RAM_ARB_FIXED_PRIO_EN makes port 0 always win a tie.
// Rev    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module arb2_pick (
   input  logic req0,
   input  logic req1,
   input  logic last_id,
   output logic grant_id,
   output logic valid
);

   always_comb begin
      valid = req0 | req1;
`ifdef RAM_ARB_FIXED_PRIO_EN
      grant_id = req0 ? 1'b0 : 1'b1;
`else
      // On a tie, favour whichever port was not served last
      if (req0 && req1) begin
         grant_id = ~last_id;
      end else begin
         grant_id = req0 ? 1'b0 : 1'b1;
      end
`endif
   end

endmodule

`default_nettype wire

// File: rtl/ram_arb.sv
//==============================================================================
// Module : ram_arb
// Desc   : Two-port arbiter and CE/WR/OE strobe sequencer for an async
//          tri-state SRAM. Build option: RAM_ARB_FIXED_PRIO_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module ram_arb
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int STRB_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [RAM_DW-1:0] wdata0,
   input  logic [RAM_DW-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [RAM_DW-1:0] rdata0,
   output logic [RAM_DW-1:0] rdata1,
   output logic              ram_ce,
   output logic              ram_wr,
   output logic              ram_oe,
   output logic [ADDR_W-1:0] ram_addr,
   inout  wire  [RAM_DW-1:0] ram_data
);

   localparam int              CNT_W    = $clog2(STRB_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRB_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   port_id_t            port_q, port_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [RAM_DW-1:0]   wdata_q, wdata_d;
   logic [RAM_DW-1:0]   rdata0_q, rdata0_d;
   logic [RAM_DW-1:0]   rdata1_q, rdata1_d;
   logic                ce_q, ce_d;
   logic                wr_q, wr_d;
   logic                oe_q, oe_d;
   logic                drv_q, drv_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic                pick_id;
   logic                pick_valid;
   logic                last_id;

`ifdef RAM_ARB_FIXED_PRIO_EN
   assign last_id = 1'b0;
`else
   port_id_t            last_q, last_d;
   assign last_id = last_q;
`endif

   arb2_pick u_pick (
      .req0     (req0),
      .req1     (req1),
      .last_id  (last_id),
      .grant_id (pick_id),
      .valid    (pick_valid)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      port_d   = port_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_d   = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_SETUP;
               port_d  = pick_id;
               we_d    = pick_id ? we1    : we0;
               addr_d  = pick_id ? addr1  : addr0;
               wdata_d = pick_id ? wdata1 : wdata0;
`ifndef RAM_ARB_FIXED_PRIO_EN
               last_d  = pick_id;
`endif
            end
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
            cnt_d   = CNT_LOAD;
         end
         ST_STROBE: begin
            if (cnt_q == CNT_ONE) begin
               state_d = ST_DONE;
               // Read data is sampled on the edge closing the OE window
               if (!we_q) begin
                  if (port_q) begin
                     rdata1_d = ram_data;
                  end else begin
                     rdata0_d = ram_data;
                  end
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Strobes are registered, so they are decoded from the upcoming state
      ce_d   = (state_d != ST_IDLE) && !((state_d == ST_DONE) && !we_d);
      wr_d   = (state_d == ST_STROBE) && we_d;
      oe_d   = ((state_d == ST_SETUP) || (state_d == ST_STROBE)) && !we_d;
      drv_d  = (state_d != ST_IDLE) && we_d;
      ack0_d = (state_d == ST_DONE) && !port_d;
      ack1_d = (state_d == ST_DONE) && port_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         port_q   <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         ce_q     <= 1'b0;
         wr_q     <= 1'b0;
         oe_q     <= 1'b0;
         drv_q    <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         port_q   <= port_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         ce_q     <= ce_d;
         wr_q     <= wr_d;
         oe_q     <= oe_d;
         drv_q    <= drv_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
      end
   end

`ifndef RAM_ARB_FIXED_PRIO_EN
   // Reset to port 1 so that port 0 wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   assign ram_data = drv_q ? wdata_q : {RAM_DW{1'bz}};
   assign ram_ce   = ce_q;
   assign ram_wr   = wr_q;
   assign ram_oe   = oe_q;
   assign ram_addr = addr_q;
   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arb.sv
//==============================================================================
// Module : tb_ram_arb
// Desc   : Scoreboard bench for ram_arb; instance 0 uses STRB_CYC=1,
//          instance 1 uses STRB_CYC=3, each with its own SRAM model.
// Rev    : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram_arb;
   import ram_arb_pkg::*;

   localparam int AW = 5;

   typedef struct {
      int         d;
      logic       port;
      logic       we;
      logic [7:0] rd;
   } sb_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst    [2];
   logic          req0   [2];
   logic          req1   [2];
   logic          we0    [2];
   logic          we1    [2];
   logic [AW-1:0] addr0  [2];
   logic [AW-1:0] addr1  [2];
   logic [7:0]    wdata0 [2];
   logic [7:0]    wdata1 [2];
   logic          ack0   [2];
   logic          ack1   [2];
   logic [7:0]    rdata0 [2];
   logic [7:0]    rdata1 [2];
   logic          ram_ce [2];
   logic          ram_wr [2];
   logic          ram_oe [2];
   logic [AW-1:0] ram_addr [2];

   sb_t sb[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  wr_cnt [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int S = (g == 0) ? 1 : 3;
      wire  [7:0] bus;
      logic [7:0] mem [32];
      sb_t        e;

      ram_arb #(.ADDR_W(AW), .STRB_CYC(S)) u_dut (
         .clk      (clk),
         .rst      (rst[g]),
         .req0     (req0[g]),
         .req1     (req1[g]),
         .we0      (we0[g]),
         .we1      (we1[g]),
         .addr0    (addr0[g]),
         .addr1    (addr1[g]),
         .wdata0   (wdata0[g]),
         .wdata1   (wdata1[g]),
         .ack0     (ack0[g]),
         .ack1     (ack1[g]),
         .rdata0   (rdata0[g]),
         .rdata1   (rdata1[g]),
         .ram_ce   (ram_ce[g]),
         .ram_wr   (ram_wr[g]),
         .ram_oe   (ram_oe[g]),
         .ram_addr (ram_addr[g]),
         .ram_data (bus)
      );

      assign bus = (ram_ce[g] && ram_oe[g] && !ram_wr[g]) ? mem[ram_addr[g]] : 8'bz;

      always @(posedge clk) begin
         if (ram_ce[g] && ram_wr[g]) mem[ram_addr[g]] <= bus;
      end

      always @(negedge clk) begin
         chk("oe_and_wr", {31'd0, ram_oe[g] & ram_wr[g]}, 32'd0);
         chk("oe_and_drive", {31'd0, ram_oe[g] & u_dut.drv_q}, 32'd0);
         if (ram_wr[g]) wr_cnt[g]++;
         if (ack0[g] || ack1[g]) begin
            chk("ack_both", {31'd0, ack0[g] & ack1[g]}, 32'd0);
            if (sb.size() == 0) begin
               chk("ack_without_request", sb.size(), 32'd1);
            end else begin
               e = sb.pop_front();
               chk("ack_instance", g, e.d);
               chk("ack_port", {31'd0, ack1[g]}, {31'd0, e.port});
               if (!e.we) chk("rdata", e.port ? rdata1[g] : rdata0[g], e.rd);
            end
         end
      end
   end

   task automatic access(input int d, input logic p, input logic we,
                         input logic [AW-1:0] a, input logic [7:0] wd,
                         input logic [7:0] rd_exp);
      int n;
      int s;
      s = (d == 0) ? 1 : 3;
      sb.push_back('{d, p, we, rd_exp});
      wr_cnt[d] = 0;
      @(negedge clk);
      if (p) begin
         req1[d] = 1'b1; we1[d] = we; addr1[d] = a; wdata1[d] = wd;
      end else begin
         req0[d] = 1'b1; we0[d] = we; addr0[d] = a; wdata0[d] = wd;
      end
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!(ack0[d] || ack1[d]) && n < 50);
      chk("ack_latency", n, s + 2);
      req0[d] = 1'b0;
      req1[d] = 1'b0;
      @(negedge clk);
      chk("wr_cycles", wr_cnt[d], we ? s : 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      int n;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; req0[i] = 1'b0; req1[i] = 1'b0; we0[i] = 1'b0; we1[i] = 1'b0;
         addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0; wr_cnt[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ce", {31'd0, ram_ce[0]}, 32'd0);
      chk("rst_wr", {31'd0, ram_wr[0]}, 32'd0);
      chk("rst_oe", {31'd0, ram_oe[0]}, 32'd0);
      chk("rst_addr", ram_addr[0], 32'd0);
      chk("rst_ack", {30'd0, ack0[0], ack1[0]}, 32'd0);
      chk("rst_rdata", {16'd0, rdata0[0], rdata1[0]}, 32'd0);
      chk("rst_drive", {31'd0, g_dut[0].u_dut.drv_q}, 32'd0);
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      // Basic write then read-back from the other port (STRB_CYC=1)
      access(0, 1'b0, 1'b1, 5'h03, 8'hA5, 8'h00);
      chk("mem_03", g_dut[0].mem[3], 32'hA5);
      access(0, 1'b1, 1'b0, 5'h03, 8'h00, 8'hA5);
      chk("idle_drive", {31'd0, g_dut[0].u_dut.drv_q}, 32'd0);
      access(0, 1'b0, 1'b1, 5'h04, 8'h3C, 8'h00);
      access(0, 1'b0, 1'b0, 5'h04, 8'h00, 8'h3C);
      chk("rdata1_held", rdata1[0], 32'hA5);

      // Simultaneous held requests on a fresh instance (STRB_CYC=3)
`ifdef RAM_ARB_FIXED_PRIO_EN
      sb.push_back('{1, 1'b0, 1'b1, 8'h00});
      sb.push_back('{1, 1'b0, 1'b1, 8'h00});
      sb.push_back('{1, 1'b0, 1'b1, 8'h00});
      sb.push_back('{1, 1'b0, 1'b1, 8'h00});
`else
      sb.push_back('{1, 1'b0, 1'b1, 8'h00});
      sb.push_back('{1, 1'b1, 1'b1, 8'h00});
      sb.push_back('{1, 1'b0, 1'b1, 8'h00});
      sb.push_back('{1, 1'b1, 1'b1, 8'h00});
`endif
      @(negedge clk);
      req0[1] = 1'b1; we0[1] = 1'b1; addr0[1] = 5'h08; wdata0[1] = 8'h11;
      req1[1] = 1'b1; we1[1] = 1'b1; addr1[1] = 5'h09; wdata1[1] = 8'h22;
      k = 0;
      n = 0;
      while (k < 4 && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (ack0[1] || ack1[1]) k++;
      end
      req0[1] = 1'b0;
      req1[1] = 1'b0;
      chk("alt_ack_count", k, 32'd4);
      @(negedge clk);
      chk("mem_08", g_dut[1].mem[8], 32'h11);
`ifndef RAM_ARB_FIXED_PRIO_EN
      chk("mem_09", g_dut[1].mem[9], 32'h22);
`endif

      // Longer strobe window at the top address
      access(1, 1'b0, 1'b1, 5'h1F, 8'h5A, 8'h00);
      access(1, 1'b1, 1'b0, 5'h1F, 8'h00, 8'h5A);

      // Reset during the STROBE phase of a write
      @(negedge clk);
      req0[1] = 1'b1; we0[1] = 1'b1; addr0[1] = 5'h10; wdata0[1] = 8'h77;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("in_strobe", {31'd0, ram_wr[1]}, 32'd1);
      rst[1] = 1'b1;
      req0[1] = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_strobes", {29'd0, ram_ce[1], ram_wr[1], ram_oe[1]}, 32'd0);
      chk("rst_mid_drive", {31'd0, g_dut[1].u_dut.drv_q}, 32'd0);
      chk("rst_mid_ack", {30'd0, ack0[1], ack1[1]}, 32'd0);
      chk("rst_mid_state", {30'd0, g_dut[1].u_dut.state_q}, {30'd0, ST_IDLE});
      @(negedge clk);
      rst[1] = 1'b0;
      access(1, 1'b1, 1'b0, 5'h1F, 8'h00, 8'h5A);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
